// File: rtl/ena_pkg.sv
// Shared types and length-bound helpers for the enable-window decoder.
package ena_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    IDLE    = 2'd1,
    ACTIVE  = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  function automatic int unsigned lo_of(input int unsigned n, input int unsigned tol);
    return (n > tol) ? (n - tol) : 1;
  endfunction

  function automatic int unsigned hi_of(input int unsigned n, input int unsigned tol);
    return n + tol;
  endfunction

endpackage

// File: rtl/ena_sat_counter.sv
// Window length counter: load to 1, increment, saturate at limit, otherwise hold.
module ena_sat_counter #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/ena_window_decoder.sv
// Reduces a stretched enable window to start / length-valid strobes and checks its length.
module ena_window_decoder
  import ena_pkg::*;
#(
  parameter int unsigned N   = 1,
  parameter int unsigned TOL = 0,
  parameter int unsigned CW  = 32,
  parameter int unsigned NW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  output logic          start_pulse,
  output logic          len_valid,
  output logic [CW-1:0] len_out,
  output logic          err_short,
  output logic          err_long,
  output logic [NW-1:0] win_count
);

  localparam logic [CW-1:0] LO    = CW'(lo_of(N, TOL));
  localparam logic [CW-1:0] HI    = CW'(hi_of(N, TOL));
  localparam logic [CW-1:0] HI_P1 = CW'(hi_of(N, TOL) + 1);

  state_t        state;
  logic          load;
  logic          inc;
  logic [CW-1:0] len_cnt;
  logic          at_hi;

  always_comb begin
    load = (state == IDLE) && ena;
    inc  = (state == ACTIVE) && ena;
  end

  ena_sat_counter #(
    .CW(CW)
  ) u_len_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .inc     (inc),
    .limit   (HI),
    .count   (len_cnt),
    .at_limit(at_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SYNC;
      start_pulse <= 1'b0;
      len_valid   <= 1'b0;
      len_out     <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      win_count   <= '0;
    end else begin
      start_pulse <= 1'b0;
      len_valid   <= 1'b0;
      err_long    <= 1'b0;
      case (state)
        // A window already high when reset releases is skipped entirely.
        SYNC: if (!ena) state <= IDLE;
        IDLE: begin
          if (ena) begin
            state       <= ACTIVE;
            start_pulse <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ena) begin
            if (at_hi) begin
              state    <= OVERRUN;
              err_long <= 1'b1;
            end
          end else begin
            len_valid <= 1'b1;
            len_out   <= len_cnt;
            err_short <= (len_cnt < LO);
            win_count <= win_count + 1'b1;
            state     <= IDLE;
          end
        end
        OVERRUN: begin
          if (!ena) begin
            len_valid <= 1'b1;
            len_out   <= HI_P1;
            err_short <= 1'b0;
            win_count <= win_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ena_window_decoder.sv
// Scoreboard bench: two decoders (TOL=0 and TOL=1) share stimulus; a run-length model predicts strobes.
module tb_ena_window_decoder;

  localparam int unsigned NN = 4;
  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 1;

  typedef struct packed {
    int unsigned edge_no;
    logic [1:0]  kind;    // 0 start, 1 err_long, 2 len_valid
    logic [31:0] len;
    logic        es;
    logic [3:0]  wc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0;

  logic        sp0, lv0, es0, el0, sp1, lv1, es1, el1;
  logic [31:0] lo0, lo1;
  logic [3:0]  wc0, wc1;

  ena_window_decoder #(.N(NN), .TOL(T0), .CW(32), .NW(4)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .start_pulse(sp0), .len_valid(lv0),
    .len_out(lo0), .err_short(es0), .err_long(el0), .win_count(wc0)
  );

  ena_window_decoder #(.N(NN), .TOL(T1), .CW(32), .NW(4)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .start_pulse(sp1), .len_valid(lv1),
    .len_out(lo1), .err_short(es1), .err_long(el1), .win_count(wc1)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned edge_no = 0;
  bit          rst_edge = 1'b0;
  ev_t         q0[$];
  ev_t         q1[$];
  bit          armed[2];
  int unsigned run[2];
  int unsigned cnt[2];

  task automatic chk(input string name, input int d, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL dut%0d %s @edge %0d: got %0d want %0d", d, name, edge_no, got, want);
    end
  endtask

  function automatic int unsigned lo_bound(input int d);
    int unsigned tol = (d == 0) ? T0 : T1;
    return (NN > tol) ? NN - tol : 1;
  endfunction

  function automatic int unsigned hi_bound(input int d);
    return NN + ((d == 0) ? T0 : T1);
  endfunction

  task automatic push(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qdrop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  // Reference: count consecutive high samples after the first low seen since reset.
  task automatic model_step(input int d);
    ev_t e;
    int unsigned hi = hi_bound(d);
    e = '0;
    e.edge_no = edge_no;
    if (!rst) begin
      armed[d] = 1'b0;
      run[d]   = 0;
      cnt[d]   = 0;
    end else if (!armed[d]) begin
      if (!ena) armed[d] = 1'b1;
    end else if (ena) begin
      run[d]++;
      if (run[d] == 1) begin e.kind = 2'd0; push(d, e); end
      if (run[d] == hi + 1) begin e.kind = 2'd1; push(d, e); end
    end else begin
      if (run[d] > 0) begin
        cnt[d]++;
        e.kind = 2'd2;
        e.len  = (run[d] > hi) ? hi + 1 : run[d];
        e.es   = (run[d] < lo_bound(d));
        e.wc   = 4'(cnt[d] % 16);
        push(d, e);
      end
      run[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    edge_no++;
    rst_edge = !rst;
    model_step(0);
    model_step(1);
  end

  task automatic mon(input int d, input logic sp, input logic lv, input logic el,
                     input logic [31:0] lo, input logic es, input logic [3:0] wc);
    ev_t e;
    logic obs;
    if (rst_edge) begin
      chk("reset_outputs", d, {sp, lv, el, es, (lo != 0), (wc != 0)}, 0);
      return;
    end
    while (qsize(d) > 0 && qfront(d).edge_no < edge_no) begin
      e = qfront(d);
      qdrop(d);
      chk("missed_strobe_kind", d, 99, e.kind);
    end
    for (int k = 0; k < 3; k++) begin
      obs = (k == 0) ? sp : (k == 1) ? el : lv;
      if (qsize(d) > 0 && qfront(d).edge_no == edge_no && qfront(d).kind == 2'(k)) begin
        e = qfront(d);
        qdrop(d);
        chk("strobe_present", d, obs, 1);
        if (k == 2 && obs) begin
          chk("len_out", d, lo, e.len);
          chk("err_short", d, es, e.es);
        end
      end else if (obs) begin
        chk("unexpected_strobe_kind", d, k, 99);
      end
    end
    chk("win_count", d, wc, cnt[d] % 16);
  endtask

  always @(negedge clk) begin
    if (edge_no > 0) begin
      mon(0, sp0, lv0, el0, lo0, es0, wc0);
      mon(1, sp1, lv1, el1, lo1, es1, wc1);
    end
  end

  task automatic step(input logic r, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      rst = r;
      ena = e;
    end
  endtask

  task automatic window(input int hi_cycles, input int lo_cycles);
    step(1'b1, 1'b1, hi_cycles);
    step(1'b1, 1'b0, lo_cycles);
  endtask

  initial begin
    step(1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 2);
    window(4, 3);
    window(2, 3);
    window(7, 3);
    window(4, 1);
    window(4, 3);
    // reset mid-window, released while ena still high
    step(1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 2);
    step(1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 2);
    window(4, 3);
    for (int i = 0; i < 17; i++) window(4, 1);
    step(1'b1, 1'b0, 2);
    window(3, 2);
    window(6, 2);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end
      window($urandom_range(1, 9), $urandom_range(1, 3));
    end
    step(1'b1, 1'b0, 6);
    @(negedge clk);
    #1;
    chk("queue0_empty", 0, q0.size(), 0);
    chk("queue1_empty", 1, q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
